// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
// The fetch unit is the master: it issues Imem_Req/Imem_Addr and receives
// Imem_Ready (request accepted) plus Imem_Valid/Imem_Rdata (response).
interface pc_fetch_unit_if #(
   parameter int unsigned WIDTH_DATA_LENGTH = 32
);
   logic                         Imem_Req;
   logic [WIDTH_DATA_LENGTH-1:0] Imem_Addr;
   logic                         Imem_Ready;
   logic                         Imem_Valid;
   logic [WIDTH_DATA_LENGTH-1:0] Imem_Rdata;

   modport master (
      output Imem_Req,
      output Imem_Addr,
      input  Imem_Ready,
      input  Imem_Valid,
      input  Imem_Rdata
   );

   modport slave (
      input  Imem_Req,
      input  Imem_Addr,
      output Imem_Ready,
      output Imem_Valid,
      output Imem_Rdata
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: keeps at most one instruction-memory request in
// flight, holds the returned instruction until downstream consumes it, and
// redirects on taken branches. A response belonging to a request that was
// overtaken by a branch is dropped rather than presented.
module pc_fetch_unit #(
   parameter int unsigned                WIDTH_DATA_LENGTH = 32,
   parameter logic [WIDTH_DATA_LENGTH-1:0] RESET_PC        = 32'h0000_0000,
   parameter logic [WIDTH_DATA_LENGTH-1:0] NOP_INST        = 32'h0000_0013
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         PC_Fetch_EN,
   input  logic                         Br_Taken,
   input  logic [WIDTH_DATA_LENGTH-1:0] Br_Target,
   pc_fetch_unit_if.master              imem,
   output logic [WIDTH_DATA_LENGTH-1:0] PC_Out,
   output logic [WIDTH_DATA_LENGTH-1:0] Inst_Out,
   output logic                         Inst_Valid,
   output logic [15:0]                  Stall_Cycles
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t                         state_q, state_d;
   logic [WIDTH_DATA_LENGTH-1:0]   pc_q, pc_d;
   logic                           drop_q, drop_d;
   logic [WIDTH_DATA_LENGTH-1:0]   inst_out_q, inst_out_d;
   logic [WIDTH_DATA_LENGTH-1:0]   pc_out_q, pc_out_d;
   logic                           inst_valid_q, inst_valid_d;
   logic [15:0]                    stall_q, stall_d;

   logic [WIDTH_DATA_LENGTH-1:0]   br_pc;
   logic                           handshake;

   // Branch targets are forced to word alignment by clearing the low two bits.
   assign br_pc     = Br_Target & ~(WIDTH_DATA_LENGTH'(3));

   // Request is a pure decode of state and PC so the address is stable while
   // the memory is not ready.
   assign imem.Imem_Req  = (state_q == FETCH);
   assign imem.Imem_Addr = pc_q;
   assign handshake      = imem.Imem_Req & imem.Imem_Ready;

   assign PC_Out       = pc_out_q;
   assign Inst_Out     = inst_out_q;
   assign Inst_Valid   = inst_valid_q;
   assign Stall_Cycles = stall_q;

   // Next-state and next-register decode; every register holds unless changed.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drop_d       = drop_q;
      inst_out_d   = inst_out_q;
      pc_out_d     = pc_out_q;
      inst_valid_d = inst_valid_q;
      stall_d      = stall_q;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end

         FETCH: begin
            if (Br_Taken) begin
               pc_d = br_pc;
            end
            if (handshake) begin
               // A request accepted in the same cycle as a redirect is stale.
               state_d = WAIT;
               drop_d  = Br_Taken;
            end
         end

         WAIT: begin
            if (Br_Taken) begin
               pc_d = br_pc;
               if (imem.Imem_Valid) begin
                  drop_d  = 1'b0;
                  state_d = FETCH;
               end else begin
                  drop_d  = 1'b1;
               end
            end else if (imem.Imem_Valid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = FETCH;
               end else begin
                  inst_out_d   = imem.Imem_Rdata;
                  pc_out_d     = pc_q;
                  inst_valid_d = 1'b1;
                  pc_d         = pc_q + WIDTH_DATA_LENGTH'(4);
                  state_d      = HOLD;
               end
            end
         end

         HOLD: begin
            if (Br_Taken) begin
               pc_d         = br_pc;
               inst_valid_d = 1'b0;
               inst_out_d   = NOP_INST;
               state_d      = FETCH;
            end else if (PC_Fetch_EN) begin
               inst_valid_d = 1'b0;
               state_d      = FETCH;
            end else if (stall_q != '1) begin
               stall_d = stall_q + 16'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: PC, drop flag, held instruction and stall counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         drop_q       <= 1'b0;
         inst_out_q   <= NOP_INST;
         pc_out_q     <= RESET_PC;
         inst_valid_q <= 1'b0;
         stall_q      <= '0;
      end else begin
         pc_q         <= pc_d;
         drop_q       <= drop_d;
         inst_out_q   <= inst_out_d;
         pc_out_q     <= pc_out_d;
         inst_valid_q <= inst_valid_d;
         stall_q      <= stall_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit. Memory behaviour is driven directly
// by each scenario task; accepted instructions are queued as expectations when
// the response is driven and compared when Inst_Valid appears.
module tb_pc_fetch_unit;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] RPC2  = 32'hFFFF_FFFC;
   localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        br;
   logic [31:0] br_tgt;

   logic [31:0] pc_out, inst_out, pc_out2, inst_out2;
   logic        inst_valid, inst_valid2;
   logic [15:0] stall, stall2;

   int unsigned errors;
   int unsigned checks;
   exp_t        sb_q[$];
   exp_t        e;

   pc_fetch_unit_if #(.WIDTH_DATA_LENGTH(32)) bus ();
   pc_fetch_unit_if #(.WIDTH_DATA_LENGTH(32)) bus2 ();

   pc_fetch_unit #(
      .WIDTH_DATA_LENGTH(32),
      .RESET_PC(32'h0000_0000),
      .NOP_INST(NOP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .PC_Fetch_EN(en), .Br_Taken(br),
      .Br_Target(br_tgt), .imem(bus.master), .PC_Out(pc_out),
      .Inst_Out(inst_out), .Inst_Valid(inst_valid), .Stall_Cycles(stall)
   );

   pc_fetch_unit #(
      .WIDTH_DATA_LENGTH(32),
      .RESET_PC(RPC2),
      .NOP_INST(NOP)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .PC_Fetch_EN(en), .Br_Taken(br),
      .Br_Target(br_tgt), .imem(bus2.master), .PC_Out(pc_out2),
      .Inst_Out(inst_out2), .Inst_Valid(inst_valid2), .Stall_Cycles(stall2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; br = 1'b0; br_tgt = '0;
      bus.Imem_Ready = 1'b0; bus.Imem_Valid = 1'b0; bus.Imem_Rdata = '0;
      bus2.Imem_Ready = 1'b0; bus2.Imem_Valid = 1'b0; bus2.Imem_Rdata = '0;
      repeat (2) step();
      checks++; if (bus.Imem_Req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", bus.Imem_Req); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
      checks++; if (inst_out !== NOP) begin errors++; $display("FAIL rst_inst: got %h expected %h", inst_out, NOP); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc_out: got %h expected 0", pc_out); end
      checks++; if (stall !== 16'h0) begin errors++; $display("FAIL rst_stall: got %h expected 0", stall); end
      checks++; if (pc_out2 !== RPC2) begin errors++; $display("FAIL rst_pc_out2: got %h expected %h", pc_out2, RPC2); end
      rst_n = 1'b1;
      checks++; if (bus.Imem_Req !== 1'b0) begin errors++; $display("FAIL rel_idle_req: got %b expected 0", bus.Imem_Req); end
      step();
      checks++; if (bus.Imem_Req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", bus.Imem_Req); end
      checks++; if (bus.Imem_Addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 0", bus.Imem_Addr); end
   endtask

   task automatic test_basic_fetch();
      logic [31:0] insts[3];
      logic [31:0] exp_addr;
      insts[0] = 32'h0050_0093; insts[1] = 32'h00a0_0113; insts[2] = 32'h0020_81b3;
      exp_addr = 32'h0;
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.Imem_Req !== 1'b1) begin errors++; $display("FAIL basic_req[%0d]: got %b expected 1", i, bus.Imem_Req); end
         checks++; if (bus.Imem_Addr !== exp_addr) begin errors++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, bus.Imem_Addr, exp_addr); end
         bus.Imem_Ready = 1'b1;
         step();
         bus.Imem_Ready = 1'b0;
         checks++; if (bus.Imem_Req !== 1'b0) begin errors++; $display("FAIL basic_wait_req[%0d]: got %b expected 0", i, bus.Imem_Req); end
         bus.Imem_Valid = 1'b1; bus.Imem_Rdata = insts[i];
         sb_q.push_back('{exp_addr, insts[i]});
         step();
         bus.Imem_Valid = 1'b0; bus.Imem_Rdata = '0;
         checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b expected 1", i, inst_valid); end
         e = sb_q.pop_front();
         checks++; if (pc_out !== e.pc) begin errors++; $display("FAIL basic_pc_out[%0d]: got %h expected %h", i, pc_out, e.pc); end
         checks++; if (inst_out !== e.inst) begin errors++; $display("FAIL basic_inst[%0d]: got %h expected %h", i, inst_out, e.inst); end
         step();
         checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed[%0d]: got %b expected 0", i, inst_valid); end
         exp_addr = exp_addr + 32'd4;
      end
   endtask

   task automatic test_stall();
      en = 1'b0;
      bus.Imem_Ready = 1'b1;
      step();
      bus.Imem_Ready = 1'b0;
      bus.Imem_Valid = 1'b1; bus.Imem_Rdata = 32'h00c0_0193;
      sb_q.push_back('{32'h0000_000C, 32'h00c0_0193});
      step();
      bus.Imem_Valid = 1'b0;
      e = sb_q.pop_front();
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", inst_valid); end
      checks++; if (pc_out !== e.pc) begin errors++; $display("FAIL stall_pc_out: got %h expected %h", pc_out, e.pc); end
      checks++; if (inst_out !== e.inst) begin errors++; $display("FAIL stall_inst: got %h expected %h", inst_out, e.inst); end
      for (int k = 1; k <= 5; k++) begin
         step();
         checks++; if (bus.Imem_Req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b expected 0", k, bus.Imem_Req); end
         checks++; if (inst_out !== e.inst || pc_out !== e.pc || inst_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %h/%h/%b expected %h/%h/1", k, inst_out, pc_out, inst_valid, e.inst, e.pc); end
      end
      checks++; if (stall !== 16'd5) begin errors++; $display("FAIL stall_count: got %0d expected 5", stall); end
      en = 1'b1;
      step();
      checks++; if (stall !== 16'd5) begin errors++; $display("FAIL stall_kept: got %0d expected 5", stall); end
      checks++; if (bus.Imem_Addr !== 32'h10 || bus.Imem_Req !== 1'b1) begin errors++; $display("FAIL stall_next_addr: got %h/%b expected 00000010/1", bus.Imem_Addr, bus.Imem_Req); end
   endtask

   task automatic test_branch_hold();
      bus.Imem_Ready = 1'b1;
      step();
      bus.Imem_Ready = 1'b0;
      bus.Imem_Valid = 1'b1; bus.Imem_Rdata = 32'h0000_0513;
      sb_q.push_back('{32'h0000_0010, 32'h0000_0513});
      step();
      bus.Imem_Valid = 1'b0;
      e = sb_q.pop_front();
      checks++; if (inst_valid !== 1'b1 || inst_out !== e.inst || pc_out !== e.pc) begin errors++; $display("FAIL bh_capture: got %b/%h/%h expected 1/%h/%h", inst_valid, inst_out, pc_out, e.inst, e.pc); end
      en = 1'b0; br = 1'b1; br_tgt = 32'h300;
      step();
      br = 1'b0; en = 1'b1;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL bh_valid: got %b expected 0", inst_valid); end
      checks++; if (inst_out !== NOP) begin errors++; $display("FAIL bh_nop: got %h expected %h", inst_out, NOP); end
      checks++; if (bus.Imem_Req !== 1'b1 || bus.Imem_Addr !== 32'h300) begin errors++; $display("FAIL bh_addr: got %b/%h expected 1/00000300", bus.Imem_Req, bus.Imem_Addr); end
      checks++; if (stall !== 16'd5) begin errors++; $display("FAIL bh_stall: got %0d expected 5", stall); end
   endtask

   task automatic test_branch_wait();
      // Redirect while waiting, response arrives later and is dropped.
      bus.Imem_Ready = 1'b1;
      step();
      bus.Imem_Ready = 1'b0;
      br = 1'b1; br_tgt = 32'h103;
      step();
      br = 1'b0;
      checks++; if (bus.Imem_Req !== 1'b0) begin errors++; $display("FAIL bw_still_wait: got %b expected 0", bus.Imem_Req); end
      bus.Imem_Valid = 1'b1; bus.Imem_Rdata = JUNK;
      step();
      bus.Imem_Valid = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL bw_dropped: got %b expected 0", inst_valid); end
      checks++; if (bus.Imem_Req !== 1'b1 || bus.Imem_Addr !== 32'h100) begin errors++; $display("FAIL bw_addr: got %b/%h expected 1/00000100", bus.Imem_Req, bus.Imem_Addr); end
      checks++; if (inst_out !== NOP) begin errors++; $display("FAIL bw_inst: got %h expected %h", inst_out, NOP); end
      // Redirect in the same cycle the response arrives.
      bus.Imem_Ready = 1'b1;
      step();
      bus.Imem_Ready = 1'b0;
      br = 1'b1; br_tgt = 32'h400; bus.Imem_Valid = 1'b1; bus.Imem_Rdata = JUNK;
      step();
      br = 1'b0; bus.Imem_Valid = 1'b0;
      checks++; if (inst_valid !== 1'b0 || bus.Imem_Req !== 1'b1 || bus.Imem_Addr !== 32'h400) begin errors++; $display("FAIL bw_same_cycle: got %b/%b/%h expected 0/1/00000400", inst_valid, bus.Imem_Req, bus.Imem_Addr); end
      // Redirect in the same cycle the request is accepted.
      bus.Imem_Ready = 1'b1; br = 1'b1; br_tgt = 32'h500;
      step();
      bus.Imem_Ready = 1'b0; br = 1'b0;
      checks++; if (bus.Imem_Req !== 1'b0) begin errors++; $display("FAIL bf_to_wait: got %b expected 0", bus.Imem_Req); end
      bus.Imem_Valid = 1'b1; bus.Imem_Rdata = JUNK;
      step();
      bus.Imem_Valid = 1'b0;
      checks++; if (inst_valid !== 1'b0 || bus.Imem_Req !== 1'b1 || bus.Imem_Addr !== 32'h500) begin errors++; $display("FAIL bf_dropped: got %b/%b/%h expected 0/1/00000500", inst_valid, bus.Imem_Req, bus.Imem_Addr); end
      // Normal fetch after the drop flag has cleared.
      bus.Imem_Ready = 1'b1;
      step();
      bus.Imem_Ready = 1'b0;
      bus.Imem_Valid = 1'b1; bus.Imem_Rdata = 32'h0010_0073;
      sb_q.push_back('{32'h0000_0500, 32'h0010_0073});
      step();
      bus.Imem_Valid = 1'b0;
      e = sb_q.pop_front();
      checks++; if (inst_valid !== 1'b1 || inst_out !== e.inst || pc_out !== e.pc) begin errors++; $display("FAIL bw_recover: got %b/%h/%h expected 1/%h/%h", inst_valid, inst_out, pc_out, e.inst, e.pc); end
      step();
   endtask

   task automatic test_ready_stall();
      for (int k = 0; k < 3; k++) begin
         checks++; if (bus.Imem_Req !== 1'b1 || bus.Imem_Addr !== 32'h504) begin errors++; $display("FAIL rs_stable[%0d]: got %b/%h expected 1/00000504", k, bus.Imem_Req, bus.Imem_Addr); end
         if (k == 1) begin
            bus.Imem_Valid = 1'b1; bus.Imem_Rdata = JUNK;
         end
         step();
         bus.Imem_Valid = 1'b0;
      end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rs_valid_ignored: got %b expected 0", inst_valid); end
      br = 1'b1; br_tgt = 32'h200;
      step();
      br = 1'b0;
      checks++; if (bus.Imem_Req !== 1'b1 || bus.Imem_Addr !== 32'h200) begin errors++; $display("FAIL rs_redirect: got %b/%h expected 1/00000200", bus.Imem_Req, bus.Imem_Addr); end
      bus.Imem_Ready = 1'b1;
      step();
      bus.Imem_Ready = 1'b0;
      bus.Imem_Valid = 1'b1; bus.Imem_Rdata = 32'h0020_8233;
      sb_q.push_back('{32'h0000_0200, 32'h0020_8233});
      step();
      bus.Imem_Valid = 1'b0;
      e = sb_q.pop_front();
      checks++; if (inst_valid !== 1'b1 || inst_out !== e.inst || pc_out !== e.pc) begin errors++; $display("FAIL rs_capture: got %b/%h/%h expected 1/%h/%h", inst_valid, inst_out, pc_out, e.inst, e.pc); end
      step();
      checks++; if (bus.Imem_Addr !== 32'h204) begin errors++; $display("FAIL rs_next_addr: got %h expected 00000204", bus.Imem_Addr); end
   endtask

   task automatic test_reset_mid_wait();
      bus.Imem_Ready = 1'b1;
      step();
      bus.Imem_Ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.Imem_Req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL mr_req_valid: got %b/%b expected 0/0", bus.Imem_Req, inst_valid); end
      checks++; if (inst_out !== NOP || pc_out !== 32'h0) begin errors++; $display("FAIL mr_outs: got %h/%h expected %h/00000000", inst_out, pc_out, NOP); end
      checks++; if (stall !== 16'h0) begin errors++; $display("FAIL mr_stall: got %0d expected 0", stall); end
      step();
      bus.Imem_Valid = 1'b1; bus.Imem_Rdata = JUNK;
      rst_n = 1'b1;
      checks++; if (bus.Imem_Req !== 1'b0) begin errors++; $display("FAIL mr_idle: got %b expected 0", bus.Imem_Req); end
      step();
      bus.Imem_Valid = 1'b0;
      checks++; if (inst_valid !== 1'b0 || bus.Imem_Req !== 1'b1 || bus.Imem_Addr !== 32'h0) begin errors++; $display("FAIL mr_late_resp: got %b/%b/%h expected 0/1/00000000", inst_valid, bus.Imem_Req, bus.Imem_Addr); end
   endtask

   task automatic test_wrap();
      checks++; if (bus2.Imem_Req !== 1'b1 || bus2.Imem_Addr !== RPC2) begin errors++; $display("FAIL wrap_first: got %b/%h expected 1/%h", bus2.Imem_Req, bus2.Imem_Addr, RPC2); end
      bus2.Imem_Ready = 1'b1;
      step();
      bus2.Imem_Ready = 1'b0;
      bus2.Imem_Valid = 1'b1; bus2.Imem_Rdata = 32'h0000_0093;
      sb_q.push_back('{RPC2, 32'h0000_0093});
      step();
      bus2.Imem_Valid = 1'b0;
      e = sb_q.pop_front();
      checks++; if (inst_valid2 !== 1'b1 || inst_out2 !== e.inst || pc_out2 !== e.pc) begin errors++; $display("FAIL wrap_capture: got %b/%h/%h expected 1/%h/%h", inst_valid2, inst_out2, pc_out2, e.inst, e.pc); end
      step();
      checks++; if (bus2.Imem_Req !== 1'b1 || bus2.Imem_Addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %b/%h expected 1/00000000", bus2.Imem_Req, bus2.Imem_Addr); end
   endtask

   task automatic test_stall_saturation();
      en = 1'b0;
      bus.Imem_Ready = 1'b1;
      step();
      bus.Imem_Ready = 1'b0;
      bus.Imem_Valid = 1'b1; bus.Imem_Rdata = 32'h0030_0293;
      sb_q.push_back('{32'h0000_0000, 32'h0030_0293});
      step();
      bus.Imem_Valid = 1'b0;
      e = sb_q.pop_front();
      checks++; if (inst_valid !== 1'b1 || inst_out !== e.inst || pc_out !== e.pc) begin errors++; $display("FAIL sat_capture: got %b/%h/%h expected 1/%h/%h", inst_valid, inst_out, pc_out, e.inst, e.pc); end
      repeat (65534) step();
      checks++; if (stall !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h expected fffe", stall); end
      step();
      checks++; if (stall !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h expected ffff", stall); end
      repeat (3) step();
      checks++; if (stall !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", stall); end
      checks++; if (inst_valid !== 1'b1 || inst_out !== e.inst) begin errors++; $display("FAIL sat_inst_kept: got %b/%h expected 1/%h", inst_valid, inst_out, e.inst); end
      en = 1'b1;
      step();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_basic_fetch();
      test_stall();
      test_branch_hold();
      test_branch_wait();
      test_ready_stall();
      test_reset_mid_wait();
      test_wrap();
      test_stall_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
